// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: data-memory request/grant/response bus.
// The master side (memory_access_unit) drives the request fields; the slave
// side (data memory) answers with grant, read-valid and read data.
interface memory_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                dmem_req;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [XLEN/8-1:0]   dmem_be;
  logic [XLEN-1:0]     dmem_wdata;
  logic                dmem_gnt;
  logic                dmem_rvalid;
  logic [XLEN-1:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: pipelined-core memory stage between execute and
// writeback. Issues byte/half/word(/dword for XLEN=64) loads and stores over
// a request/grant/response bus, stalls earlier stages while an access is
// outstanding and registers the result toward writeback.
// XLEN must be 32 or 64. For XLEN=32 a size code of 3 is treated as a word.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, an access whose
// offset is not a multiple of its size is not issued and is reported through
// out_misalign. When undefined, the offending low address bits are cleared so
// the access becomes naturally aligned, and out_misalign stays 0.
module memory_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [1:0]           in_size,
  input  logic                 in_unsigned,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [XLEN-1:0]      in_wdata,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic                 flush,
  output logic                 stall_m,
  memory_access_unit_if.master dmem,
  output logic                 out_valid,
  output logic [4:0]           out_rd,
  output logic                 out_reg_write,
  output logic [XLEN-1:0]      out_result,
  output logic                 out_misalign
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Size code actually used: a dword request on a 32-bit datapath is a word.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    logic [1:0] s;
    if ((XLEN == 32) && (size == 2'd3)) begin
      s = 2'd2;
    end else begin
      s = size;
    end
    return s;
  endfunction

  // Low offset bits that must be zero for a naturally aligned access.
  function automatic logic [OFF_W-1:0] size_mask(input logic [1:0] size);
    logic [OFF_W-1:0] m;
    for (int i = 0; i < OFF_W; i++) begin
      m[i] = (i < int'(size));
    end
    return m;
  endfunction

  // One enable per byte lane covered by (1 << size) bytes starting at off.
  function automatic logic [NBYTES-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
    logic [NBYTES-1:0] be;
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (32'sd1 <<< size);
    for (int i = 0; i < NBYTES; i++) begin
      be[i] = (i >= lo) && (i < hi);
    end
    return be;
  endfunction

  // Pick the addressed lanes out of the read word and extend to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic uns);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    logic            top;
    int              nbits;
    lane  = rdata >> {off, 3'b000};
    nbits = 32'sd8 <<< size;
    case (size)
      2'd0:    top = lane[7];
      2'd1:    top = lane[15];
      2'd2:    top = lane[31];
      default: top = lane[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      res[i] = (i < nbits) ? lane[i] : (top & ~uns);
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic                st_q, st_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [4:0]          rd_q, rd_d;
  logic                regw_q, regw_d;
  logic                kill_q, kill_d;

  logic                out_valid_q, out_valid_d;
  logic [4:0]          out_rd_q, out_rd_d;
  logic                out_reg_write_q, out_reg_write_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic                out_misalign_q, out_misalign_d;

  logic [1:0]          in_size_eff;
  logic [OFF_W-1:0]    in_off;
  logic [OFF_W-1:0]    align_mask;
  logic [OFF_W-1:0]    acc_off;
  logic                acc_trap;
  logic [ADDR_W-1:0]   acc_addr;
  logic [NBYTES-1:0]   acc_be;
  logic [XLEN-1:0]     acc_wdata;
  logic                is_mem;

  logic                stall_s;
  logic                req_s;
  logic                we_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [NBYTES-1:0]   be_s;
  logic [XLEN-1:0]     wdata_s;

  // Turn the execute-stage operands into an aligned bus access.
  always_comb begin
    in_size_eff = eff_size(in_size);
    in_off      = in_addr[OFF_W-1:0];
    align_mask  = size_mask(in_size_eff);
`ifdef MEM_MISALIGN_TRAP_EN
    acc_trap    = ((in_off & align_mask) != {OFF_W{1'b0}});
    acc_off     = in_off;
`else
    acc_trap    = 1'b0;
    acc_off     = in_off & ~align_mask;
`endif
    acc_addr    = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    acc_be      = byte_enable(in_size_eff, acc_off);
    if (in_mem_write) begin
      acc_wdata = in_wdata << {acc_off, 3'b000};
    end else begin
      acc_wdata = {XLEN{1'b0}};
    end
    is_mem      = in_valid & (in_mem_read | in_mem_write);
  end

  // Next-state, bus drive, stall and writeback-register update logic.
  always_comb begin
    state_d         = state_q;
    st_d            = st_q;
    addr_d          = addr_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    uns_d           = uns_q;
    off_d           = off_q;
    rd_d            = rd_q;
    regw_d          = regw_q;
    kill_d          = kill_q;
    out_valid_d     = 1'b0;
    out_rd_d        = out_rd_q;
    out_reg_write_d = 1'b0;
    out_result_d    = out_result_q;
    out_misalign_d  = 1'b0;
    stall_s         = 1'b0;
    req_s           = 1'b0;
    we_s            = 1'b0;
    addr_s          = {ADDR_W{1'b0}};
    be_s            = {NBYTES{1'b0}};
    wdata_s         = {XLEN{1'b0}};

    case (state_q)
      ST_IDLE: begin
        // rstn qualifies acceptance so nothing is requested while in reset.
        if (rstn && is_mem && !flush) begin
          if (acc_trap) begin
            out_valid_d    = 1'b1;
            out_misalign_d = 1'b1;
            out_rd_d       = in_rd;
            out_result_d   = in_alu_result;
          end else begin
            req_s   = 1'b1;
            we_s    = in_mem_write;
            addr_s  = acc_addr;
            be_s    = acc_be;
            wdata_s = acc_wdata;
            st_d    = in_mem_write;
            addr_d  = acc_addr;
            be_d    = acc_be;
            wdata_d = acc_wdata;
            size_d  = in_size_eff;
            uns_d   = in_unsigned;
            off_d   = acc_off;
            rd_d    = in_rd;
            regw_d  = in_reg_write;
            kill_d  = 1'b0;
            if (dmem.dmem_gnt) begin
              if (in_mem_write) begin
                // Store granted at once: this is already its completion cycle.
                out_valid_d  = 1'b1;
                out_rd_d     = in_rd;
                out_result_d = in_alu_result;
              end else begin
                state_d = ST_WAIT;
                stall_s = 1'b1;
              end
            end else begin
              state_d = ST_REQ;
              stall_s = 1'b1;
            end
          end
        end else begin
          out_valid_d     = in_valid & ~flush;
          out_rd_d        = in_rd;
          out_reg_write_d = in_valid & ~flush & in_reg_write;
          out_result_d    = in_alu_result;
        end
      end

      ST_REQ: begin
        req_s   = 1'b1;
        we_s    = st_q;
        addr_s  = addr_q;
        be_s    = be_q;
        wdata_s = wdata_q;
        if (dmem.dmem_gnt) begin
          if (st_q) begin
            state_d     = ST_IDLE;
            out_valid_d = ~flush;
            out_rd_d    = rd_q;
          end else begin
            // Once granted the response must be drained even if flushed.
            state_d = ST_WAIT;
            kill_d  = flush;
            stall_s = 1'b1;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end

      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d = ST_IDLE;
          if (kill_q || flush) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d     = 1'b1;
            out_rd_d        = rd_q;
            out_reg_write_d = regw_q;
            out_result_d    = load_extend(dmem.dmem_rdata, size_q, off_q, uns_q);
          end
        end else begin
          kill_d  = kill_q | flush;
          stall_s = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched access fields and writeback registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      st_q            <= 1'b0;
      addr_q          <= {ADDR_W{1'b0}};
      be_q            <= {NBYTES{1'b0}};
      wdata_q         <= {XLEN{1'b0}};
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      off_q           <= {OFF_W{1'b0}};
      rd_q            <= 5'd0;
      regw_q          <= 1'b0;
      kill_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      out_rd_q        <= 5'd0;
      out_reg_write_q <= 1'b0;
      out_result_q    <= {XLEN{1'b0}};
      out_misalign_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      st_q            <= st_d;
      addr_q          <= addr_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      off_q           <= off_d;
      rd_q            <= rd_d;
      regw_q          <= regw_d;
      kill_q          <= kill_d;
      out_valid_q     <= out_valid_d;
      out_rd_q        <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      out_result_q    <= out_result_d;
      out_misalign_q  <= out_misalign_d;
    end
  end

  assign stall_m         = stall_s;
  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = we_s;
  assign dmem.dmem_addr  = addr_s;
  assign dmem.dmem_be    = be_s;
  assign dmem.dmem_wdata = wdata_s;

  assign out_valid     = out_valid_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign out_result    = out_result_q;
  assign out_misalign  = out_misalign_q;

endmodule
